// File: rtl/TYPES.sv
// Shared types, opcode/width constants and lane helpers for the SIMD multiply/AND datapath.
package TYPES;

    typedef logic [255:0] prng_t;

    localparam logic [2:0] MODE_MUL = 3'b100;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_RSV = 3'b001;

    localparam logic [2:0] W32  = 3'b000;
    localparam logic [2:0] W64  = 3'b001;
    localparam logic [2:0] W128 = 3'b011;
    localparam logic [2:0] W256 = 3'b111;

    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_MUL  = 2'd1,
        OP_AND  = 2'd2
    } op_e;

    function automatic op_e decode_mode(input logic [2:0] mode);
        op_e op;
        case (mode)
            MODE_MUL: op = OP_MUL;
            MODE_AND: op = OP_AND;
            MODE_RSV: op = OP_ZERO;
            default:  op = OP_ZERO;
        endcase
        return op;
    endfunction

    // log2 of 32-bit chunks per lane; unlisted codes fall back to the highest set bit
    function automatic logic [1:0] width_log2(input logic [2:0] w);
        logic [1:0] lw;
        if (w == W256 || w[2])
            lw = 2'd3;
        else if (w == W128 || w[1])
            lw = 2'd2;
        else if (w == W64 || w[0])
            lw = 2'd1;
        else
            lw = 2'd0;
        return lw;
    endfunction

    // One bit per lane, at the lane MSB
    function automatic prng_t lane_msb(input logic [1:0] lw);
        prng_t m;
        m = '0;
        for (int c = 0; c < 8; c++) begin
            if (((c + 1) % (1 << lw)) == 0)
                m[32*c+31] = 1'b1;
        end
        return m;
    endfunction

    // Position tile x_i*y_j inside its lane; zero when the chunks sit in different
    // lanes or the local shift reaches the lane width, truncated at the lane top.
    function automatic prng_t place_tile(input logic [63:0] p, input int i, input int j,
                                         input logic [1:0] lw);
        int    n;
        int    b;
        int    s;
        prng_t v;
        prng_t m;
        n = 1 << lw;
        b = (i >> lw) << lw;
        s = (i - b) + (j - b);
        v = '0;
        m = '0;
        if (((i >> lw) == (j >> lw)) && (s < n)) begin
            v = prng_t'(p) << (32 * (i + j - b));
            for (int c = 0; c < 8; c++) begin
                if ((c >> lw) == (i >> lw))
                    m[32*c +: 32] = '1;
            end
            v = v & m;
        end
        return v;
    endfunction

    function automatic prng_t csa_sum(input prng_t a, input prng_t b, input prng_t c);
        return a ^ b ^ c;
    endfunction

    // Carry shifted up within the lane; the carry out of each lane MSB is dropped
    function automatic prng_t csa_cy(input prng_t a, input prng_t b, input prng_t c,
                                     input logic [1:0] lw);
        return (((a & b) | (a & c) | (b & c)) & ~lane_msb(lw)) << 1;
    endfunction

endpackage

// File: rtl/mul32_tile.sv
// Registered 32x32 unsigned partial-product tile.
// Latency: 1 cycle.
// Backpressure: none, accepts an operand pair every cycle.
module mul32_tile (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            p_o <= '0;
        else
            p_o <= {32'b0, a_i} * {32'b0, b_i};
    end

endmodule

// File: rtl/simd_muland_unit.sv
// SIMD lane-wise multiply (mod 2^w) / bitwise AND, result in carry-save form.
// Latency: 9 register stages, input at edge t shows after edge t+8.
// Backpressure: none, one result per cycle, never stalls.
module simd_muland_unit
    import TYPES::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  prng_t       x_i,
    input  prng_t       y_i,
    input  logic [2:0]  mode_i,
    input  logic [2:0]  width_i,
    output prng_t       ps_o,
    output prng_t       sc_o
);

    prng_t       x_q, y_q, and_q;
    op_e         op1, op2;
    logic [1:0]  lw1, lw2, lw3, lw4, lw5, lw6, lw7, lw8;
    logic [63:0] p_q [8][8];

    prng_t t3_d [16];
    prng_t t3   [16];
    prng_t l4_d [11];
    prng_t l4   [11];
    prng_t l5_d [8];
    prng_t l5   [8];
    prng_t l6_d [6];
    prng_t l6   [6];
    prng_t l7_d [4];
    prng_t l7   [4];
    prng_t l8_d [3];
    prng_t l8   [3];

    // Stage 1: input register with decoded sideband
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q <= '0;
            y_q <= '0;
            op1 <= OP_ZERO;
            lw1 <= '0;
        end else begin
            x_q <= x_i;
            y_q <= y_i;
            op1 <= decode_mode(mode_i);
            lw1 <= width_log2(width_i);
        end
    end

    // Stage 2: full 8x8 tile array; lane masking later picks the useful ones
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
        for (genvar gj = 0; gj < 8; gj++) begin : g_col
            mul32_tile u_tile (
                .clk_i   (clk_i),
                .rst_n_i (rst_n_i),
                .a_i     (x_q[32*gi +: 32]),
                .b_i     (y_q[32*gj +: 32]),
                .p_o     (p_q[gi][gj])
            );
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            and_q <= '0;
            op2   <= OP_ZERO;
            lw2   <= '0;
        end else begin
            and_q <= (op1 == OP_AND) ? (x_q & y_q) : '0;
            op2   <= op1;
            lw2   <= lw1;
        end
    end

    // Row i splits into even/odd-j terms, whose 64-bit products never overlap
    always_comb begin
        for (int t = 0; t < 16; t++)
            t3_d[t] = '0;
        if (op2 == OP_MUL) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    t3_d[2*i + (j % 2)] = t3_d[2*i + (j % 2)] | place_tile(p_q[i][j], i, j, lw2);
                end
            end
        end else if (op2 == OP_AND) begin
            t3_d[0] = and_q;
        end
    end

    // 3:2 levels; slot 0 always carries the sum of the first group, so the AND
    // result rides through the tree untouched and lands on ps.
    always_comb begin
        for (int g = 0; g < 5; g++) begin
            l4_d[2*g]   = csa_sum(t3[3*g], t3[3*g+1], t3[3*g+2]);
            l4_d[2*g+1] = csa_cy(t3[3*g], t3[3*g+1], t3[3*g+2], lw3);
        end
        l4_d[10] = t3[15];
    end

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            l5_d[2*g]   = csa_sum(l4[3*g], l4[3*g+1], l4[3*g+2]);
            l5_d[2*g+1] = csa_cy(l4[3*g], l4[3*g+1], l4[3*g+2], lw4);
        end
        l5_d[6] = l4[9];
        l5_d[7] = l4[10];
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            l6_d[2*g]   = csa_sum(l5[3*g], l5[3*g+1], l5[3*g+2]);
            l6_d[2*g+1] = csa_cy(l5[3*g], l5[3*g+1], l5[3*g+2], lw5);
        end
        l6_d[4] = l5[6];
        l6_d[5] = l5[7];
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            l7_d[2*g]   = csa_sum(l6[3*g], l6[3*g+1], l6[3*g+2]);
            l7_d[2*g+1] = csa_cy(l6[3*g], l6[3*g+1], l6[3*g+2], lw6);
        end
    end

    always_comb begin
        l8_d[0] = csa_sum(l7[0], l7[1], l7[2]);
        l8_d[1] = csa_cy(l7[0], l7[1], l7[2], lw7);
        l8_d[2] = l7[3];
    end

    // Stages 3..8: term register and compressor levels
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 16; k++) t3[k] <= '0;
            for (int k = 0; k < 11; k++) l4[k] <= '0;
            for (int k = 0; k < 8;  k++) l5[k] <= '0;
            for (int k = 0; k < 6;  k++) l6[k] <= '0;
            for (int k = 0; k < 4;  k++) l7[k] <= '0;
            for (int k = 0; k < 3;  k++) l8[k] <= '0;
            lw3 <= '0;
            lw4 <= '0;
            lw5 <= '0;
            lw6 <= '0;
            lw7 <= '0;
            lw8 <= '0;
        end else begin
            t3  <= t3_d;
            l4  <= l4_d;
            l5  <= l5_d;
            l6  <= l6_d;
            l7  <= l7_d;
            l8  <= l8_d;
            lw3 <= lw2;
            lw4 <= lw3;
            lw5 <= lw4;
            lw6 <= lw5;
            lw7 <= lw6;
            lw8 <= lw7;
        end
    end

    // Stage 9: final 3:2 level straight into the output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ps_o <= '0;
            sc_o <= '0;
        end else begin
            ps_o <= csa_sum(l8[0], l8[1], l8[2]);
            sc_o <= csa_cy(l8[0], l8[1], l8[2], lw8);
        end
    end

endmodule

// File: tb/tb_simd_muland_unit.sv
module tb_simd_muland_unit;
    import TYPES::*;

    logic       clk;
    logic       rst_n;
    prng_t      x, y, ps, sc;
    logic [2:0] mode, width;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic  exact;
        prng_t ps;
        prng_t sc;
        int    w;
        int    id;
    } exp_t;

    typedef struct {
        prng_t      x;
        prng_t      y;
        logic [2:0] mode;
        logic [2:0] width;
        exp_t       e;
    } vec_t;

    exp_t expq[$];
    vec_t tbl[12];

    simd_muland_unit dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .x_i     (x),
        .y_i     (y),
        .mode_i  (mode),
        .width_i (width),
        .ps_o    (ps),
        .sc_o    (sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic prng_t rand256();
        prng_t r;
        for (int c = 0; c < 8; c++) r[32*c +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [511:0] lane_mask(input int w);
        logic [511:0] one;
        one = 512'd1;
        return (one << w) - one;
    endfunction

    // Reference: independent lane products using wide arithmetic
    function automatic prng_t ref_mul(input prng_t a, input prng_t b, input int w);
        logic [511:0] m, al, bl, r;
        m = lane_mask(w);
        r = '0;
        for (int k = 0; k < 256 / w; k++) begin
            al = ({256'b0, a} >> (k * w)) & m;
            bl = ({256'b0, b} >> (k * w)) & m;
            r  = r | (((al * bl) & m) << (k * w));
        end
        return r[255:0];
    endfunction

    function automatic prng_t resolve(input prng_t p, input prng_t c, input int w);
        logic [511:0] m, pl, cl, r;
        m = lane_mask(w);
        r = '0;
        for (int k = 0; k < 256 / w; k++) begin
            pl = ({256'b0, p} >> (k * w)) & m;
            cl = ({256'b0, c} >> (k * w)) & m;
            r  = r | (((pl + cl) & m) << (k * w));
        end
        return r[255:0];
    endfunction

    function automatic int ref_width(input logic [2:0] wd);
        if (wd[2]) return 256;
        if (wd[1]) return 128;
        if (wd[0]) return 64;
        return 32;
    endfunction

    function automatic exp_t mk_exact(input prng_t p, input int id);
        exp_t e;
        e.exact = 1'b1; e.ps = p; e.sc = '0; e.w = 256; e.id = id;
        return e;
    endfunction

    function automatic exp_t mk_sum(input prng_t p, input int w, input int id);
        exp_t e;
        e.exact = 1'b0; e.ps = p; e.sc = '0; e.w = w; e.id = id;
        return e;
    endfunction

    function automatic exp_t model(input prng_t a, input prng_t b, input logic [2:0] m,
                                   input logic [2:0] wd, input int id);
        if (m == 3'b100) return mk_sum(ref_mul(a, b, ref_width(wd)), ref_width(wd), id);
        if (m == 3'b010) return mk_exact(a & b, id);
        return mk_exact('0, id);
    endfunction

    task automatic check(input exp_t e);
        prng_t r;
        vectors++;
        if (e.exact) begin
            if (ps !== e.ps || sc !== e.sc) begin
                miscompares++;
                $display("FAIL exact vec%0d: ps=%h sc=%h, want ps=%h sc=0", e.id, ps, sc, e.ps);
            end
        end else begin
            r = resolve(ps, sc, e.w);
            if (r !== e.ps) begin
                miscompares++;
                $display("FAIL lanesum vec%0d w=%0d: got %h, want %h", e.id, e.w, r, e.ps);
            end
        end
    endtask

    task automatic step(input prng_t a, input prng_t b, input logic [2:0] m,
                        input logic [2:0] wd, input exp_t e);
        @(negedge clk);
        if (expq.size() >= 9) check(expq.pop_front());
        x = a; y = b; mode = m; width = wd;
        expq.push_back(e);
    endtask

    task automatic prefill_zero();
        for (int k = 0; k < 9; k++) expq.push_back(mk_exact('0, -1));
    endtask

    initial begin
        prng_t a, b;
        logic [2:0] m, wd;
        logic [2:0] modes [6];
        modes = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b000, 3'b111};

        tbl[0]  = '{{8{32'hFFFFFFFF}}, {8{32'h00000002}}, 3'b100, W32, mk_sum({8{32'hFFFFFFFE}}, 32, 0)};
        tbl[1]  = '{{1'b1, 255'b0}, 256'd2, 3'b100, W256, mk_sum('0, 256, 1)};
        tbl[2]  = '{256'd3, 256'd5, 3'b100, W256, mk_exact(256'd15, 2)};
        tbl[3]  = '{{16{16'hAAAA}}, {8{32'hFFFF0000}}, 3'b010, W128, mk_exact({8{32'hAAAA0000}}, 3)};
        tbl[4]  = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}}, 3'b001, W64, mk_exact('0, 4)};
        tbl[5]  = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}}, 3'b110, W32, mk_exact('0, 5)};
        tbl[6]  = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}}, 3'b100, W32, mk_sum({8{32'h00000001}}, 32, 6)};
        tbl[7]  = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}}, 3'b100, W128, mk_sum({2{128'd1}}, 128, 7)};
        tbl[8]  = '{{4{64'h1_0000_0000}}, {4{64'h1_0000_0000}}, 3'b100, W64, mk_sum('0, 64, 8)};
        tbl[9]  = '{256'd1 << 128, 256'd1 << 64, 3'b100, 3'b101, mk_sum(256'd1 << 192, 256, 9)};
        tbl[10] = '{256'd1 << 64, 256'd1 << 64, 3'b010 ^ 3'b110, 3'b010, mk_sum('0, 128, 10)};
        tbl[11] = '{256'd1 << 64, 256'd1 << 64, 3'b100, 3'b100, mk_sum(256'd1 << 128, 256, 11)};
        // the exact entry for 3*5 also checks the sum carries nothing above bit 31
        tbl[2].e.exact = 1'b0;
        tbl[2].e.w = 256;

        rst_n = 1'b0; x = '0; y = '0; mode = 3'b000; width = 3'b000;
        repeat (3) @(negedge clk);
        check(mk_exact('0, 900));
        rst_n = 1'b1;
        prefill_zero();

        // zero operands across every mode and listed width
        for (int mi = 0; mi < 3; mi++)
            for (int wi = 0; wi < 4; wi++) begin
                wd = (wi == 0) ? W32 : (wi == 1) ? W64 : (wi == 2) ? W128 : W256;
                step('0, '0, modes[mi], wd, mk_exact('0, 200 + 4*mi + wi));
            end

        for (int i = 0; i < 12; i++)
            step(tbl[i].x, tbl[i].y, tbl[i].mode, tbl[i].width, tbl[i].e);

        // back-to-back multiplies with width toggling every cycle
        for (int n = 0; n < 40; n++) begin
            a = rand256(); b = rand256();
            wd = n[0] ? W128 : W64;
            step(a, b, 3'b100, wd, model(a, b, 3'b100, wd, 300 + n));
        end

        // mixed modes and arbitrary width codes
        for (int n = 0; n < 40; n++) begin
            a = rand256(); b = rand256();
            m = modes[$urandom_range(0, 5)];
            wd = 3'($urandom_range(0, 7));
            step(a, b, m, wd, model(a, b, m, wd, 400 + n));
        end

        for (int n = 0; n < 6; n++) begin
            a = rand256(); b = rand256();
            step(a, b, 3'b100, W256, model(a, b, 3'b100, W256, 500 + n));
        end

        // reset mid-stream: outputs clear at once, in-flight results are dropped
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(mk_exact('0, 901));
        expq.delete();
        x = '0; y = '0; mode = 3'b000; width = 3'b000;
        repeat (2) @(negedge clk);
        check(mk_exact('0, 902));
        rst_n = 1'b1;
        prefill_zero();

        for (int n = 0; n < 20; n++) begin
            a = rand256(); b = rand256();
            wd = 3'($urandom_range(0, 7));
            step(a, b, 3'b100, wd, model(a, b, 3'b100, wd, 600 + n));
        end

        for (int n = 0; n < 9; n++)
            step('0, '0, 3'b000, W32, mk_exact('0, 700 + n));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
